// File: rtl/i2c_slave_reg_if.sv
// I2C target exposing an 8-bit register space through a pointer/strobe interface.
// SCL/SDA are synchronized and glitch-filtered; SDA is only ever changed while SCL is low.
module i2c_slave_reg_if #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_e;

  localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

  // A new level is accepted only once it has been seen FILTER_LEN consecutive cycles.
  function automatic logic [4:0] filt_next(input logic in, input logic flt, input logic [3:0] cnt);
    logic [4:0] r;
    if (in == flt) begin
      r = {flt, 4'd0};
    end else if (cnt >= FILT_MAX) begin
      r = {in, 4'd0};
    end else begin
      r = {flt, cnt + 4'd1};
    end
    return r;
  endfunction

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       oe_q, oe_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       done_q, done_d;
  logic       load_q, load_d;
  logic       mack_q, mack_d;

  logic       scl_rise, scl_fall, start_evt, stop_evt;
  logic [7:0] rx_byte;

  // Input path next values: two-flop synchronizer, stability filter, previous-level register.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_pad_i};
    sda_sync_d = {sda_sync_q[0], sda_pad_i};
    {scl_flt_d, scl_cnt_d} = filt_next(scl_sync_q[1], scl_flt_q, scl_cnt_q);
    {sda_flt_d, sda_cnt_d} = filt_next(sda_sync_q[1], sda_flt_q, sda_cnt_q);
    scl_prev_d = scl_flt_q;
    sda_prev_d = sda_flt_q;
  end

  assign scl_rise  = scl_flt_q & ~scl_prev_q;
  assign scl_fall  = ~scl_flt_q & scl_prev_q;
  assign start_evt = scl_flt_q & scl_prev_q & sda_prev_q & ~sda_flt_q;
  assign stop_evt  = scl_flt_q & scl_prev_q & ~sda_prev_q & sda_flt_q;
  assign rx_byte   = {shift_q[6:0], sda_flt_q};

  // Protocol FSM: bus conditions take priority, otherwise per-state bit handling.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    oe_d      = oe_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    busy_d    = busy_q;
    rw_d      = rw_q;
    done_d    = done_q;
    load_d    = 1'b0;
    mack_d    = mack_q;
    if (stop_evt) begin
      state_d = ST_IDLE;
      oe_d    = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (start_evt) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d = 1'b1;
        end
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && rx_byte[7:1] == SLAVE_ADDR) begin
              rw_d   = rx_byte[0];
              done_d = 1'b1;
            end else if (bit_cnt_q == 3'd7) begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              done_d = 1'b0;
            end
          end else if (scl_fall && done_q) begin
            oe_d    = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = ST_ADDR_ACK;
          end else begin
            done_d = done_q;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall && rw_q) begin
            oe_d      = 1'b1;
            bit_cnt_d = 3'd0;
            re_d      = 1'b1;
            load_d    = 1'b1;
            state_d   = ST_RDATA;
          end else if (scl_fall) begin
            oe_d      = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = ST_PTR;
          end else begin
            oe_d = 1'b0;
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d = rx_byte;
              done_d = 1'b1;
            end else begin
              done_d = 1'b0;
            end
          end else if (scl_fall && done_q) begin
            oe_d    = 1'b0;
            done_d  = 1'b0;
            state_d = ST_PTR_ACK;
          end else begin
            done_d = done_q;
          end
        end
        ST_PTR_ACK: begin
          if (scl_fall) begin
            oe_d      = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = ST_WDATA;
          end else begin
            oe_d = 1'b0;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wdata_d = rx_byte;
              we_d    = 1'b1;
              done_d  = 1'b1;
            end else begin
              done_d = 1'b0;
            end
          end else if (scl_fall && done_q) begin
            oe_d    = 1'b0;
            done_d  = 1'b0;
            state_d = ST_WDATA_ACK;
          end else begin
            done_d = done_q;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            oe_d      = 1'b1;
            bit_cnt_d = 3'd0;
            addr_d    = addr_q + 8'd1;
            state_d   = ST_WDATA;
          end else begin
            oe_d = 1'b0;
          end
        end
        ST_RDATA: begin
          if (load_q) begin
            // Read data arrives one cycle after the strobe; put its MSB on the bus.
            shift_d = reg_rdata_i;
            oe_d    = reg_rdata_i[7];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            done_d    = (bit_cnt_q == 3'd7);
          end else if (scl_fall && done_q) begin
            oe_d    = 1'b1;
            done_d  = 1'b0;
            addr_d  = addr_q + 8'd1;
            state_d = ST_RDATA_ACK;
          end else if (scl_fall) begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = shift_q[6];
          end else begin
            shift_d = shift_q;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            mack_d = ~sda_flt_q;
          end else if (scl_fall && mack_q) begin
            re_d      = 1'b1;
            load_d    = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = ST_RDATA;
          end else if (scl_fall) begin
            busy_d  = 1'b0;
            state_d = ST_WAIT_STOP;
          end else begin
            mack_d = mack_q;
          end
        end
        ST_WAIT_STOP: begin
          oe_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b1;
        end
      endcase
    end
  end

  // State and input-path registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= 4'd0;
      sda_cnt_q  <= 4'd0;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      oe_q       <= 1'b1;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_flt_q  <= scl_flt_d;
      sda_flt_q  <= sda_flt_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      done_q     <= done_d;
      load_q     <= load_d;
      mack_q     <= mack_d;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oe_q;
  assign reg_addr_o   = addr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_we_o     = we_q;
  assign reg_re_o     = re_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_reg_if.sv
// Directed bench: a behavioural I2C master drives the target and checks strobes and SDA.
module tb_i2c_slave_reg_if;

  localparam int Q = 10;  // clk cycles per quarter SCL bit

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       sda_line;
  logic       sda_pad_o, sda_padoen_o;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic       reg_we_o, reg_re_o, busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] we_addr[$];
  logic [7:0] we_data[$];
  logic [7:0] re_addr[$];
  logic       oe_low_seen;

  always #5 clk = ~clk;

  assign sda_line = m_sda & (sda_padoen_o ? 1'b1 : sda_pad_o);

  // Register-file model feeding read data.
  always_comb begin
    case (reg_addr_o)
      8'h05:   reg_rdata_i = 8'h5A;
      8'h06:   reg_rdata_i = 8'hC3;
      default: reg_rdata_i = 8'h00;
    endcase
  end

  i2c_slave_reg_if #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst),
    .scl_pad_i(m_scl), .sda_pad_i(sda_line),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_we_o(reg_we_o), .reg_re_o(reg_re_o),
    .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
  );

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reg_we_o) begin
      we_addr.push_back(reg_addr_o);
      we_data.push_back(reg_wdata_o);
    end
    if (reg_re_o) re_addr.push_back(reg_addr_o);
    if (!sda_padoen_o) oe_low_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qget(input logic [7:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 8'hEE;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    we_addr.delete();
    we_data.delete();
    re_addr.delete();
    oe_low_seen = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  // One SCL bit; optional 2-clk low pulse on SDA while SCL is high.
  task automatic i2c_bit(input logic b, input logic glitch, output logic smp);
    m_sda = b; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q / 2);
    if (glitch) begin
      m_sda = 1'b0; wait_clk(2);
      m_sda = b;    wait_clk(Q / 2 - 2);
    end else begin
      wait_clk(Q / 2);
    end
    smp = sda_line; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], (i == glitch_bit), s);
    i2c_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    i2c_bit(~ack, 1'b0, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rd;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; oe_low_seen = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(3);
    check("rst_oe", sda_padoen_o, 1'b1);
    check("rst_pad_o", sda_pad_o, 1'b0);
    check("rst_addr", reg_addr_o, 8'h00);
    check("rst_wdata", reg_wdata_o, 8'h00);
    check("rst_strobes", {reg_we_o, reg_re_o}, 2'b00);
    check("rst_busy", busy_o, 1'b0);

    // Write burst
    clear_mon();
    i2c_start();
    write_byte(8'hA0, -1, ack); check("wb_ack_addr", ack, 1'b1);
    check("wb_busy", busy_o, 1'b1);
    write_byte(8'h10, -1, ack); check("wb_ack_ptr", ack, 1'b1);
    write_byte(8'h11, -1, ack); check("wb_ack_d0", ack, 1'b1);
    write_byte(8'h22, -1, ack); check("wb_ack_d1", ack, 1'b1);
    check("wb_busy_before_p", busy_o, 1'b1);
    i2c_stop();
    check("wb_we_count", we_addr.size(), 16'd2);
    check("wb_we0", {qget(we_addr, 0), qget(we_data, 0)}, 16'h1011);
    check("wb_we1", {qget(we_addr, 1), qget(we_data, 1)}, 16'h1122);
    check("wb_addr", reg_addr_o, 8'h12);
    check("wb_busy_after_p", busy_o, 1'b0);
    check("wb_no_re", re_addr.size(), 16'd0);

    // Random read with repeated START
    clear_mon();
    i2c_start();
    write_byte(8'hA0, -1, ack); check("rr_ack_addr", ack, 1'b1);
    write_byte(8'h05, -1, ack); check("rr_ack_ptr", ack, 1'b1);
    i2c_start();
    write_byte(8'hA1, -1, ack); check("rr_ack_raddr", ack, 1'b1);
    read_byte(rd, 1'b1); check("rr_byte0", rd, 8'h5A);
    read_byte(rd, 1'b0); check("rr_byte1", rd, 8'hC3);
    check("rr_oe_after_nack", sda_padoen_o, 1'b1);
    check("rr_busy_after_nack", busy_o, 1'b0);
    i2c_stop();
    check("rr_re_count", re_addr.size(), 16'd2);
    check("rr_re_addrs", {qget(re_addr, 0), qget(re_addr, 1)}, 16'h0506);
    check("rr_addr", reg_addr_o, 8'h07);
    check("rr_no_we", we_addr.size(), 16'd0);

    // Address mismatch
    clear_mon();
    i2c_start();
    write_byte(8'hA2, -1, ack); check("mm_nack_addr", ack, 1'b0);
    check("mm_busy", busy_o, 1'b0);
    write_byte(8'h00, -1, ack); check("mm_nack_data", ack, 1'b0);
    i2c_stop();
    check("mm_oe_never_low", oe_low_seen, 1'b0);
    check("mm_strobes", we_addr.size() + re_addr.size(), 16'd0);
    check("mm_addr_kept", reg_addr_o, 8'h07);

    // Pointer wrap
    clear_mon();
    i2c_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'hFF, -1, ack);
    write_byte(8'hAA, -1, ack);
    write_byte(8'hBB, -1, ack);
    i2c_stop();
    check("pw_we_count", we_addr.size(), 16'd2);
    check("pw_we0", {qget(we_addr, 0), qget(we_data, 0)}, 16'hFFAA);
    check("pw_we1", {qget(we_addr, 1), qget(we_data, 1)}, 16'h00BB);
    check("pw_addr", reg_addr_o, 8'h01);

    // Glitch inside a full data byte, then STOP after 4 bits of the next byte
    clear_mon();
    i2c_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h30, -1, ack);
    write_byte(8'h9C, 7, ack); check("ab_glitch_ack", ack, 1'b1);
    i2c_bit(1'b1, 1'b0, s);
    i2c_bit(1'b0, 1'b0, s);
    i2c_bit(1'b1, 1'b0, s);
    i2c_bit(1'b0, 1'b0, s);
    i2c_stop();
    check("ab_we_count", we_addr.size(), 16'd1);
    check("ab_we0", {qget(we_addr, 0), qget(we_data, 0)}, 16'h309C);
    check("ab_addr", reg_addr_o, 8'h31);
    check("ab_idle", {busy_o, sda_padoen_o}, 2'b01);

    // Reset during the address ACK
    clear_mon();
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(((8'hA0 >> i) & 8'h01) != 8'h00, 1'b0, s);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2);
    check("rs_oe_acking", sda_padoen_o, 1'b0);
    rst = 1'b1;
    wait_clk(1);
    check("rs_oe_released", sda_padoen_o, 1'b1);
    check("rs_outputs", {reg_addr_o, reg_wdata_o}, 16'h0000);
    check("rs_flags", {reg_we_o, reg_re_o, busy_o}, 3'b000);
    rst = 1'b0;
    wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
    i2c_stop();
    clear_mon();
    i2c_start();
    write_byte(8'hA0, -1, ack); check("rs_ack_addr", ack, 1'b1);
    write_byte(8'h40, -1, ack);
    write_byte(8'h77, -1, ack); check("rs_ack_data", ack, 1'b1);
    i2c_stop();
    check("rs_we_count", we_addr.size(), 16'd1);
    check("rs_we0", {qget(we_addr, 0), qget(we_data, 0)}, 16'h4077);
    check("rs_addr", reg_addr_o, 8'h41);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
